muldiv_arbiter: RTL and testbench
=================================

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 Parameter N SHALL be: N, default 5, operand/result width in bits (signed two's complement).
REQ-002 Clocking and reset SHALL be: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 Port clk SHALL be: clk  input  1  rising-edge clock.
REQ-004 Port rst_n SHALL be: rst_n  input  1  async active-low reset.
REQ-005 Port req_valid SHALL be: req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 Port req_ready SHALL be: req_ready  output  2  per-requester accept pulse.
REQ-007 Port req_op SHALL be: req_op  input  4  opcode, requester i on bits [2i+1:2i]; 00 divide, 01 multiply.
REQ-008 Port req_a SHALL be: req_a  input  2N  operand A (dividend/multiplicand), requester i on [iN+N-1:iN].
REQ-009 Port req_b SHALL be: req_b  input  2N  operand B (divisor/multiplier), same packing.
REQ-010 Port rsp_valid SHALL be: rsp_valid  output  1  result available.
REQ-011 Port rsp_ready SHALL be: rsp_ready  input  1  consumer accepts result.
REQ-012 Port rsp_id SHALL be: rsp_id  output  1  requester index owning the result.
REQ-013 Port rsp_hi SHALL be: rsp_hi  output  N  quotient (divide) or upper N bits of 2N-bit product (multiply).
REQ-014 Port rsp_lo SHALL be: rsp_lo  output  N  remainder (divide) or lower N bits of product (multiply).
REQ-015 Port rsp_err SHALL be: rsp_err  output  1  divide-by-zero or illegal opcode.

Function
REQ-016 FSM SHALL have states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-017 In IDLE with any req_valid set, the block SHALL grant one requester, pulse its req_ready for exactly one cycle, register op/a/b/id, and go to EXEC.
REQ-018 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; with a single requester valid, grant it regardless of pointer.
REQ-019 In EXEC, the block SHALL drive registered operands to the combinational unit and register rsp_hi/rsp_lo/rsp_err at the cycle end, then go to RESP.
REQ-020 In RESP, rsp_valid SHALL be high and all rsp_* outputs stable until rsp_ready; on rsp_valid&&rsp_ready the FSM SHALL return to IDLE.
REQ-021 Latency SHALL be: accept at cycle T, rsp_valid first high at T+2; minimum issue interval 3 cycles.
REQ-022 Divide SHALL truncate toward zero; remainder SHALL take the dividend's sign.
REQ-023 Divide with B=0 or opcode 10/11 SHALL set rsp_err=1 and force rsp_hi=rsp_lo=0.
REQ-024 Requesters SHALL hold req_valid and operands until req_ready; the block SHALL NOT sample operands outside the accept cycle.
REQ-025 req_ready SHALL be 0 in EXEC and RESP.

Reset
REQ-026 On rst_n low, state SHALL be IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_hi=0, rsp_lo=0, rsp_err=0, and the RR pointer SHALL favour requester 0.
REQ-027 Reset mid-operation SHALL discard the in-flight operation with no response issued.

Configuration
REQ-028 With MULDIV_ARB_STATS_EN defined, the block SHALL add outputs stat_ops[15:0] (completed handshakes) and stat_errs[15:0] (completions with rsp_err), both saturating at 16'hFFFF and reset to 0; without the macro, these ports and counters SHALL NOT exist.

Structure
REQ-029 Package muldiv_pkg SHALL hold the opcode constants (OP_DIV=2'b00, OP_MUL=2'b01) and the FSM state typedef.
REQ-030 The block SHALL instantiate the existing Multi_Divid_Comb unit as its datapath plus one sub-module, muldiv_rr_arb (2-way round-robin grant with pointer).

Verification
REQ-031 N=5, req 0 divide 13/2 -> rsp_hi=6, rsp_lo=1, rsp_err=0, rsp_id=0, rsp_valid at T+2.
REQ-032 Req 1 divide -7/2 -> rsp_hi=-3, rsp_lo=-1; req 1 multiply -6*7 -> rsp_hi=-2, rsp_lo=-10.
REQ-033 Divide 13/0 and opcode 2'b11 -> rsp_err=1, rsp_hi=rsp_lo=0.
REQ-034 Both requesters valid continuously for 4 operations -> grants alternate 0,1,0,1.
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_* stable, no new req_ready; reset asserted in EXEC -> no response, all outputs 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared opcode constants and FSM state type for the two-port
//                multiply/divide arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Opcode encoding as seen on req_op (two bits per requester).
    // Codes 2'b10 and 2'b11 are reserved and complete with rsp_err set.
    localparam logic [1:0] OP_DIV = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;

    // One operation in flight: accept -> compute -> hold result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/Multi_Divid_Comb.sv
`default_nettype none
// ============================================================================
//  Module      : Multi_Divid_Comb
//  Description : Purely combinational signed N-bit multiply / divide unit.
//                Divide truncates toward zero; the remainder carries the
//                dividend's sign. Divide-by-zero and reserved opcodes raise
//                o_err and force both result halves to zero.
//  Ports       : i_op [1:0]     opcode (OP_DIV / OP_MUL)
//                i_a  [N-1:0]   dividend / multiplicand (two's complement)
//                i_b  [N-1:0]   divisor / multiplier   (two's complement)
//                o_hi [N-1:0]   quotient / upper product half
//                o_lo [N-1:0]   remainder / lower product half
//                o_err          divide-by-zero or reserved opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module Multi_Divid_Comb
    import muldiv_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [1:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_hi,
    output logic [N-1:0] o_lo,
    output logic         o_err
);

    // Magnitudes carry one extra bit so the most negative value has a
    // representable absolute value.
    logic           w_a_neg;
    logic           w_b_neg;
    logic [N:0]     w_a_ext;
    logic [N:0]     w_b_ext;
    logic [N:0]     w_a_mag;
    logic [N:0]     w_b_mag;
    logic [N:0]     w_q_mag;
    logic [N:0]     w_r_mag;
    logic [N-1:0]   w_quo;
    logic [N-1:0]   w_rem;
    logic [2*N-1:0] w_prod;
    logic           w_unused_bits;

    assign w_a_neg = i_a[N-1];
    assign w_b_neg = i_b[N-1];
    assign w_a_ext = {i_a[N-1], i_a};
    assign w_b_ext = {i_b[N-1], i_b};
    assign w_a_mag = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_b_mag = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;

    // Guard the zero divisor so the unsigned divider never sees it.
    assign w_q_mag = (w_b_mag == '0) ? '0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == '0) ? '0 : (w_a_mag % w_b_mag);

    // Sign restore: quotient negative when signs differ, remainder follows
    // the dividend. -2^(N-1) / -1 wraps back to -2^(N-1), remainder 0.
    assign w_quo = (w_a_neg ^ w_b_neg) ? (~w_q_mag[N-1:0] + 1'b1) : w_q_mag[N-1:0];
    assign w_rem = w_a_neg ? (~w_r_mag[N-1:0] + 1'b1) : w_r_mag[N-1:0];

    // Sign-extended operands multiplied modulo 2^(2N) give the exact signed
    // 2N-bit product.
    assign w_prod = {{N{i_a[N-1]}}, i_a} * {{N{i_b[N-1]}}, i_b};

    // Magnitude MSBs only matter for the wrap case and are dropped on truncation.
    assign w_unused_bits = w_q_mag[N] ^ w_r_mag[N];

    always_comb begin
        o_hi  = '0;
        o_lo  = '0;
        o_err = 1'b0;
        case (i_op)
            OP_DIV: begin
                if (i_b == '0) begin
                    o_err = 1'b1;
                end else begin
                    o_hi = w_quo;
                    o_lo = w_rem;
                end
            end
            OP_MUL: begin
                o_hi = w_prod[2*N-1:N];
                o_lo = w_prod[N-1:0];
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

endmodule : Multi_Divid_Comb
`default_nettype wire

// File: rtl/muldiv_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_rr_arb
//  Description : Two-way round-robin grant selector. On a tie the favoured
//                requester wins; a lone requester always wins. The favour
//                pointer flips to the other requester each accepted grant.
//  Ports       : clk, rst_n     clock, async active-low reset
//                i_req [1:0]    request vector
//                i_accept       grant consumed this cycle (advance pointer)
//                o_any          at least one request pending
//                o_gnt_id       index of the selected requester
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_any,
    output logic       o_gnt_id
);

    // Index favoured on the next tie; 0 out of reset.
    logic r_prio;

    always_comb begin
        o_any = |i_req;
        if (i_req == 2'b11) begin
            o_gnt_id = r_prio;
        end else begin
            o_gnt_id = i_req[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_accept) begin
            r_prio <= ~o_gnt_id;
        end
    end

endmodule : muldiv_rr_arb
`default_nettype wire

// File: rtl/muldiv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_arbiter
//  Description : Two requesters share one signed multiply/divide unit.
//                IDLE grants one requester (round-robin) and latches its
//                operands, EXEC captures the combinational result, RESP
//                holds it until the consumer takes it. Accept at cycle T
//                gives rsp_valid at T+2; issue interval is at least 3.
//  Ports       : clk, rst_n          clock, async active-low reset
//                req_valid [1:0]     per-requester request
//                req_ready [1:0]     one-cycle accept pulse (IDLE only)
//                req_op    [3:0]     opcode, requester i on [2i+1:2i]
//                req_a/req_b [2N-1:0] operands, requester i on [iN+N-1:iN]
//                rsp_valid/rsp_ready result handshake
//                rsp_id              owner of the result
//                rsp_hi/rsp_lo [N-1:0] quotient/remainder or product halves
//                rsp_err             divide-by-zero or reserved opcode
//                stat_ops/stat_errs [15:0] saturating completion counters,
//                                    present only with MULDIV_ARB_STATS_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_arbiter
    import muldiv_pkg::*;
#(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [3:0]     req_op,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [N-1:0]   rsp_hi,
    output logic [N-1:0]   rsp_lo,
    output logic           rsp_err
`ifdef MULDIV_ARB_STATS_EN
    ,
    output logic [15:0]    stat_ops,
    output logic [15:0]    stat_errs
`endif
);

    localparam logic [15:0] c_stat_max = 16'hFFFF;

    state_t       r_state;
    state_t       w_state_nxt;

    logic         w_any;
    logic         w_gnt_id;
    logic         w_accept;
    logic [1:0]   w_ready;
    logic         w_rsp_hs;

    logic [1:0]   r_op;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_id;
    logic [N-1:0] r_hi;
    logic [N-1:0] r_lo;
    logic         r_err;

    logic [N-1:0] w_hi;
    logic [N-1:0] w_lo;
    logic         w_err;

    // ------------------------------------------------------------------
    // Arbitration and datapath
    // ------------------------------------------------------------------
    muldiv_rr_arb u_rr_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req_valid),
        .i_accept (w_accept),
        .o_any    (w_any),
        .o_gnt_id (w_gnt_id)
    );

    // Only registered operands reach the unit, so requester lanes are never
    // observed outside the accept cycle.
    Multi_Divid_Comb #(
        .N (N)
    ) u_muldiv (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_hi  (w_hi),
        .o_lo  (w_lo),
        .o_err (w_err)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ready     = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_ready     = w_gnt_id ? 2'b10 : 2'b01;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The accept pulse is combinational in IDLE; masking with rst_n keeps it
    // low while reset is held even if requesters are already asserting.
    assign req_ready = w_ready & {2{rst_n}};
    assign w_rsp_hs  = (r_state == RESP) && rsp_ready;

    // ------------------------------------------------------------------
    // Operand capture (accept cycle only) and result capture (EXEC)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= OP_DIV;
            r_a  <= '0;
            r_b  <= '0;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_op <= req_op[2*w_gnt_id +: 2];
            r_a  <= req_a[N*w_gnt_id +: N];
            r_b  <= req_b[N*w_gnt_id +: N];
            r_id <= w_gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_err <= 1'b0;
        end else if (r_state == EXEC) begin
            r_hi  <= w_hi;
            r_lo  <= w_lo;
            r_err <= w_err;
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_id;
    assign rsp_hi    = r_hi;
    assign rsp_lo    = r_lo;
    assign rsp_err   = r_err;

`ifdef MULDIV_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Completion statistics, saturating at all-ones
    // ------------------------------------------------------------------
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_errs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops  <= '0;
            r_stat_errs <= '0;
        end else if (w_rsp_hs) begin
            if (r_stat_ops != c_stat_max) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if (r_err && (r_stat_errs != c_stat_max)) begin
                r_stat_errs <= r_stat_errs + 16'd1;
            end
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_errs = r_stat_errs;
`else
    // Handshake and ceiling are only consumed by the statistics counters.
    logic w_unused_stats;
    assign w_unused_stats = w_rsp_hs ^ (^c_stat_max);
`endif

endmodule : muldiv_arbiter
`default_nettype wire

// File: tb/tb_muldiv_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_arbiter
//  Description : Self-checking bench for muldiv_arbiter (N=5). Expected
//                results are computed from integer arithmetic when a request
//                is accepted, queued, and compared when the response is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_arbiter;
    import muldiv_pkg::*;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [3:0]     req_op = 4'b0000;
    logic [2*N-1:0] req_a = '0;
    logic [2*N-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_id;
    logic [N-1:0]   rsp_hi;
    logic [N-1:0]   rsp_lo;
    logic           rsp_err;
`ifdef MULDIV_ARB_STATS_EN
    logic [15:0]    stat_ops;
    logic [15:0]    stat_errs;
`endif

    typedef struct packed {
        logic         id;
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    muldiv_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_hi    (rsp_hi),
        .rsp_lo    (rsp_lo),
        .rsp_err   (rsp_err)
`ifdef MULDIV_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model from plain integer arithmetic.
    function automatic exp_t model(input logic id, input logic [1:0] op,
                                   input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int ia, ib, q, r, pr;
        ia = $signed(a);
        ib = $signed(b);
        e.id = id; e.hi = '0; e.lo = '0; e.err = 1'b0;
        if (op == 2'b00) begin
            if (ib == 0) begin
                e.err = 1'b1;
            end else begin
                q = ia / ib;
                r = ia % ib;
                e.hi = q[N-1:0];
                e.lo = r[N-1:0];
            end
        end else if (op == 2'b01) begin
            pr = ia * ib;
            e.hi = pr[2*N-1:N];
            e.lo = pr[N-1:0];
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic drive_req(input logic id, input logic [1:0] op,
                             input logic [N-1:0] a, input logic [N-1:0] b);
        int i;
        i = int'(id);
        req_valid[i]      = 1'b1;
        req_op[2*i +: 2]  = op;
        req_a[N*i +: N]   = a;
        req_b[N*i +: N]   = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++;
        if ({rsp_id, rsp_hi, rsp_lo, rsp_err} !== '0) begin
            errors++; $display("FAIL reset_rsp_fields got id=%b hi=%h lo=%h err=%b exp=all 0",
                               rsp_id, rsp_hi, rsp_lo, rsp_err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One request; optionally holds rsp_ready low for 5 cycles in RESP while
    // both requesters assert, to show the result is frozen and nothing is accepted.
    task automatic test_single_op(input logic id, input logic [1:0] op,
                                  input logic [N-1:0] a, input logic [N-1:0] b,
                                  input bit stall);
        exp_t e;
        int   t;
        bit   ok;
        logic [2*N+2:0] snap;
        rsp_ready = !stall;
        drive_req(id, op, a, b);
        #1;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (req_ready != 2'b00) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL accept_timeout id=%0d got no req_ready exp=pulse", id);
            req_valid = 2'b00;
            return;
        end
        checks++;
        if (req_ready !== (2'b01 << id)) begin
            errors++; $display("FAIL grant_onehot got=%b exp=%b", req_ready, 2'b01 << id);
        end
        sb.push_back(model(id, op, a, b));
        t = cyc;
        @(posedge clk); #1;
        req_valid = 2'b00;
        // Scribble on the lanes; the in-flight result must not change.
        req_a[N*int'(id) +: N] = ~a;
        req_b[N*int'(id) +: N] = ~b;
        req_op = ~req_op;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL exec_req_ready got=%b exp=00", req_ready); end
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok || cyc != t + 2) begin
            errors++; $display("FAIL latency got_cycle=%0d exp_cycle=%0d valid_seen=%0d", cyc - t, 2, ok);
        end
        if (!ok) return;
        if (stall) begin
            snap = {rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_err};
            drive_req(1'b0, OP_MUL, 5'd3, 5'd3);
            drive_req(1'b1, OP_MUL, 5'd2, 5'd2);
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                checks++;
                if ({rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_err} !== snap || req_ready !== 2'b00) begin
                    errors++; $display("FAIL stall_hold cyc=%0d got rsp=%h ready=%b exp rsp=%h ready=00",
                                       k, {rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_err}, req_ready, snap);
                end
            end
            req_valid = 2'b00;
            rsp_ready = 1'b1;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL scoreboard_empty got response exp=none");
            return;
        end
        e = sb.pop_front();
        if (rsp_id !== e.id) begin errors++; $display("FAIL rsp_id got=%0d exp=%0d", rsp_id, e.id); end
        checks++;
        if (rsp_hi !== e.hi) begin errors++; $display("FAIL rsp_hi got=%h exp=%h", rsp_hi, e.hi); end
        checks++;
        if (rsp_lo !== e.lo) begin errors++; $display("FAIL rsp_lo got=%h exp=%h", rsp_lo, e.lo); end
        checks++;
        if (rsp_err !== e.err) begin errors++; $display("FAIL rsp_err got=%b exp=%b", rsp_err, e.err); end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_hs_valid got=%b exp=0", rsp_valid); end
    endtask

    // Both requesters assert continuously; grants must alternate from 0
    // (fresh reset) and issue every 3 cycles.
    task automatic test_back_to_back();
        int   grants[$];
        int   times[$];
        int   nacc, nrsp;
        exp_t e;
        int   exp_g[4];
        exp_g = '{0, 1, 0, 1};
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        drive_req(1'b0, OP_MUL, 5'd3, 5'(-4));
        drive_req(1'b1, OP_DIV, 5'(-9), 5'd2);
        #1;
        nacc = 0; nrsp = 0;
        for (int k = 0; k < 40 && (nacc < 4 || nrsp < 4); k++) begin
            if (req_ready != 2'b00 && nacc < 4) begin
                grants.push_back(int'(req_ready[1]));
                times.push_back(cyc);
                sb.push_back(req_ready[1] ? model(1'b1, OP_DIV, 5'(-9), 5'd2)
                                          : model(1'b0, OP_MUL, 5'd3, 5'(-4)));
                nacc++;
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_scoreboard_empty got response exp=none");
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_hi, rsp_lo, rsp_err} !== {e.id, e.hi, e.lo, e.err}) begin
                        errors++; $display("FAIL b2b_rsp got id=%0d hi=%h lo=%h err=%b exp id=%0d hi=%h lo=%h err=%b",
                                           rsp_id, rsp_hi, rsp_lo, rsp_err, e.id, e.hi, e.lo, e.err);
                    end
                end
                nrsp++;
            end
            @(posedge clk); #1;
            if (nacc == 4) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        checks++;
        if (nacc != 4 || nrsp != 4) begin
            errors++; $display("FAIL b2b_count got acc=%0d rsp=%0d exp acc=4 rsp=4", nacc, nrsp);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= grants.size() || grants[i] != exp_g[i]) begin
                errors++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", i,
                                   (i < grants.size()) ? grants[i] : -1, exp_g[i]);
            end
        end
        for (int i = 1; i < times.size(); i++) begin
            checks++;
            if (times[i] - times[i-1] != 3) begin
                errors++; $display("FAIL b2b_interval%0d got=%0d exp=3", i, times[i] - times[i-1]);
            end
        end
    endtask

    // Reset while EXEC: the operation disappears and outputs clear at once.
    task automatic test_reset_mid();
        bit ok;
        bit seen;
        rsp_ready = 1'b1;
        drive_req(1'b0, OP_DIV, 5'd13, 5'd2);
        #1;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (req_ready != 2'b00) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_accept_timeout got no req_ready exp=pulse"); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready, rsp_id, rsp_hi, rsp_lo, rsp_err} !== '0) begin
            errors++; $display("FAIL rstmid_outputs got valid=%b ready=%b id=%b hi=%h lo=%h err=%b exp=all 0",
                               rsp_valid, req_ready, rsp_id, rsp_hi, rsp_lo, rsp_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rstmid_no_response got rsp_valid=1 exp=0"); end
        checks++;
        if ({rsp_id, rsp_hi, rsp_lo, rsp_err} !== '0) begin
            errors++; $display("FAIL rstmid_after got id=%b hi=%h lo=%h err=%b exp=all 0",
                               rsp_id, rsp_hi, rsp_lo, rsp_err);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        // Pointer now favours 0; a lone requester 1 must still be granted.
        test_single_op(1'b1, OP_DIV, 5'(-7), 5'd2, 1'b0);   // -3 r -1
        test_single_op(1'b0, OP_DIV, 5'd13, 5'd2, 1'b0);    //  6 r 1
        test_single_op(1'b1, OP_MUL, 5'(-6), 5'd7, 1'b0);   // -42 -> hi -2, lo -10
        test_single_op(1'b0, OP_DIV, 5'd13, 5'd0, 1'b0);    // divide by zero
        test_single_op(1'b1, 2'b11, 5'd5, 5'd3, 1'b1);      // reserved op, stalled consumer
        test_single_op(1'b0, OP_DIV, 5'(-16), 5'(-1), 1'b0);// wrap case
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_arbiter
`default_nettype wire
